// File: rtl/act_pool_pkg.sv
// Shared types and lane helpers for the activation pooling buffer.
package act_pool_pkg;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic {PAIR_EMPTY = 1'b0, PAIR_HALF = 1'b1} pool_state_t;

  // Per-lane unsigned max; lanes never interact.
  function automatic logic [VEC_W-1:0] lane_max(input logic [VEC_W-1:0] a,
                                                input logic [VEC_W-1:0] b);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*LANE_W +: LANE_W] = (a[i*LANE_W +: LANE_W] > b[i*LANE_W +: LANE_W]) ?
                              a[i*LANE_W +: LANE_W] : b[i*LANE_W +: LANE_W];
    return r;
  endfunction
endpackage

// File: rtl/act_sync_fifo.sv
// Synchronous FIFO with occupancy count; push is dropped when full (no bypass),
// pop is ignored when empty. Head word is read combinationally.
module act_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    valid    = (count_q != '0);
    push_en  = push && !full;
    pop_en   = pop && valid;
    // DEPTH is a power of two, so pointer overflow is the wrap.
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    rdata    = mem_q[rd_ptr_q];
    count    = count_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/act_pool_buffer.sv
// Activation pool buffer: pairwise per-lane max pooling (ACT_POOL_MAXPOOL_EN)
// or direct pass-through, feeding a valid/ready FIFO stream.
module act_pool_buffer
  import act_pool_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [VEC_W-1:0]       in_act,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  output logic [VEC_W-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_count
);
  logic             fifo_full;
  logic             fifo_push;
  logic [VEC_W-1:0] push_data;

`ifdef ACT_POOL_MAXPOOL_EN
  pool_state_t      state_q, state_d;
  logic [VEC_W-1:0] hold_q, hold_d;
  logic             accept;

  always_comb begin
    // Only the pair-completing step pushes, so only PAIR_HALF must stall on full.
    in_ready  = !(state_q == PAIR_HALF && fifo_full);
    accept    = in_valid && in_ready;
    state_d   = state_q;
    hold_d    = hold_q;
    fifo_push = 1'b0;
    push_data = hold_q;
    case (state_q)
      PAIR_EMPTY: begin
        if (accept) begin
          hold_d  = in_act;
          state_d = PAIR_HALF;
        end
      end
      PAIR_HALF: begin
        if (accept) begin
          fifo_push = 1'b1;
          push_data = lane_max(hold_q, in_act);
          state_d   = PAIR_EMPTY;
        end else if (flush && !fifo_full) begin
          fifo_push = 1'b1;
          state_d   = PAIR_EMPTY;
        end
      end
      default: state_d = PAIR_EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PAIR_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;

  always_comb begin
    in_ready  = !fifo_full;
    fifo_push = in_valid && in_ready;
    push_data = in_act;
  end
`endif

  act_sync_fifo #(.DEPTH(DEPTH), .WIDTH(VEC_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (out_ready),
    .rdata (out_data),
    .valid (out_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_act_pool_buffer.sv
// Directed bench for act_pool_buffer; expectations follow ACT_POOL_MAXPOOL_EN.
module tb_act_pool_buffer;
`ifdef ACT_POOL_MAXPOOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_act = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  fifo_count;

  int n_tot = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  act_pool_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_act(in_act),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic        iv;
    logic [31:0] act;
    logic        fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic nxt();
    @(posedge clock); #1;
  endtask

  task automatic feed(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_act = v;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
      nxt();
    end
    nxt();
    in_valid = 1'b0;
    if (!ok) begin
      n_tot++;
      $display("FAIL feed_timeout: in_ready stayed 0 for %h", v);
    end
  endtask

  function automatic logic [31:0] va(input int k);
    return {8'(16 + k), 8'(128 - k), 8'(k), 8'(240 - k)};
  endfunction

  // Word i of the fill sequence: pool of va(2i),va(2i+1) worked out lane by lane.
  function automatic logic [31:0] exp_a(input int i);
    return POOL ? {8'(16 + 2*i + 1), 8'(128 - 2*i), 8'(2*i + 1), 8'(240 - 2*i)} : va(i);
  endfunction

  function automatic logic [31:0] vb(input int k);
    return 32'hA0000000 | (32'(k) * 32'h00010101);
  endfunction

  function automatic logic [31:0] exp_b(input int j);
    return POOL ? vb(2*j + 1) : vb(j);
  endfunction

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nv;
`ifdef ACT_POOL_MAXPOOL_EN
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h0A140005, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h0C0F0020, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 32'h0C140020, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0C140020, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h000000FF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h000000FF, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h01020304, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h04030201, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h04030304, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
`else
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h0A140005, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b1, 32'h0C0F0020, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0A140005, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0A140005, 4'd2});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h0C0F0020, 4'd1});
    tbl.push_back('{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
    tbl.push_back('{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0});
`endif

    // Reset then idle
    nxt(); nxt();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk($sformatf("idle%0d_ov", i), 32'(out_valid), 32'd0);
      chk($sformatf("idle%0d_cnt", i), 32'(fifo_count), 32'd0);
      chk($sformatf("idle%0d_rdy", i), 32'(in_ready), 32'd1);
      nxt();
    end

    // Table vectors
    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].iv; in_act = tbl[i].act; flush = tbl[i].fl; out_ready = tbl[i].ordy;
      @(negedge clock);
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].e_cnt));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
      nxt();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // Fill until backpressure, pop one, let the pending vector complete, drain across wrap
    n = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_act = va(n);
      @(negedge clock);
      if (!in_ready) break;
      nxt();
      n++;
    end
    chk("fill_accepts", 32'(n), POOL ? 32'd17 : 32'd8);
    chk("fill_cnt", 32'(fifo_count), 32'd8);
    chk("fill_rdy", 32'(in_ready), 32'd0);
    chk("fill_ov", 32'(out_valid), 32'd1);
    nxt();
    @(negedge clock);
    chk("full_hold_cnt", 32'(fifo_count), 32'd8);
    nxt();
    out_ready = 1'b1;
    @(negedge clock);
    chk("full_pop_rdy", 32'(in_ready), 32'd0);
    chk("full_pop_data", out_data, exp_a(0));
    nxt();
    out_ready = 1'b0;
    @(negedge clock);
    chk("after_pop_cnt", 32'(fifo_count), 32'd7);
    chk("after_pop_rdy", 32'(in_ready), 32'd1);
    nxt();
    n++;
    in_valid = 1'b0;
    @(negedge clock);
    chk("refill_cnt", 32'(fifo_count), 32'd8);
    nxt();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      chk($sformatf("drain%0d_ov", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_data", i), out_data, exp_a(i));
      nxt();
    end
    out_ready = 1'b0;
    @(negedge clock);
    chk("drained_cnt", 32'(fifo_count), 32'd0);
    nxt();

    // Concurrent push and pop at count 3
    nv = POOL ? 7 : 3;
    for (int k = 0; k < nv; k++) feed(vb(k));
    in_valid = 1'b1; in_act = vb(nv); out_ready = 1'b1;
    @(negedge clock);
    chk("conc_pre_cnt", 32'(fifo_count), 32'd3);
    chk("conc_pop_data", out_data, exp_b(0));
    nxt();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    chk("conc_post_cnt", 32'(fifo_count), 32'd3);
    nxt();
    out_ready = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clock);
      chk($sformatf("conc_drain%0d", j), out_data, exp_b(j));
      nxt();
    end
    out_ready = 1'b0;
    @(negedge clock);
    chk("conc_empty_cnt", 32'(fifo_count), 32'd0);
    nxt();

    // Flush against a full FIFO is held off until a pop frees a slot
    n = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      in_act = (n == 16) ? 32'h000000FF : vb(n);
      @(negedge clock);
      if (!in_ready) break;
      nxt();
      n++;
    end
    in_valid = 1'b0;
    flush = 1'b1;
    for (int c = 0; c < 2; c++) begin
      nxt();
      @(negedge clock);
      chk($sformatf("flush_full%0d_cnt", c), 32'(fifo_count), 32'd8);
    end
    nxt();
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    @(negedge clock);
    chk("flush_pop_cnt", 32'(fifo_count), 32'd7);
    nxt();
    flush = 1'b0;
    @(negedge clock);
    chk("flush_push_cnt", 32'(fifo_count), POOL ? 32'd8 : 32'd7);
    nxt();

    // Reset mid-operation discards queue and half pair
    reset = 1'b1; nxt(); reset = 1'b0;
    @(negedge clock);
    chk("rst1_cnt", 32'(fifo_count), 32'd0);
    chk("rst1_ov", 32'(out_valid), 32'd0);
    chk("rst1_rdy", 32'(in_ready), 32'd1);
    nxt();
    nv = POOL ? 11 : 5;
    for (int k = 0; k < nv; k++) feed((k == nv - 1) ? 32'hFFFFFFFF : vb(k));
    @(negedge clock);
    chk("pre_rst_cnt", 32'(fifo_count), 32'd5);
    nxt();
    reset = 1'b1; nxt(); reset = 1'b0;
    @(negedge clock);
    chk("rst2_cnt", 32'(fifo_count), 32'd0);
    chk("rst2_ov", 32'(out_valid), 32'd0);
    nxt();
    feed(32'h33003300);
    feed(32'h00220022);
    @(negedge clock);
    chk("newpair_ov", 32'(out_valid), 32'd1);
    chk("newpair_data", out_data, POOL ? 32'h33223322 : 32'h33003300);
    chk("newpair_cnt", 32'(fifo_count), POOL ? 32'd1 : 32'd2);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/act_pool_buffer.md
Name: act_pool_buffer

Overview:
- Downstream consumer of the 4x4 MAC array's activation stage. Accepts the four 8-bit activated lane results (rsum4/8/12/16 order) as one vector per cycle.
- Pools pairs of consecutive vectors by per-lane max, then queues the pooled 32-bit words in a synchronous FIFO.
- Exposes the queued words on a valid/ready stream to the next layer's feeder or to memory writeback.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- LANES, 4, activation lanes per vector; fixed to the array width.
- LANE_W, 8, bits per lane; matches the quantized activation width.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  in_act carries a valid activation vector.
- in_act  input  32  lane0=[7:0] (rsum4), lane1=[15:8] (rsum8), lane2=[23:16] (rsum12), lane3=[31:24] (rsum16).
- in_ready  output  1  block can accept in_act this cycle.
- flush  input  1  close a half-filled pooling pair.
- out_valid  output  1  FIFO head is valid.
- out_data  output  32  FIFO head word, same lane packing as in_act.
- out_ready  input  1  consumer pops the head when out_valid=1.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, reset=1 at a clock edge): state=PAIR_EMPTY, hold register=0, read and write pointers=0, count=0, out_valid=0, fifo_count=0. out_data is don't-care while out_valid=0.
- Reset mid-operation discards any queued words and any half-filled pair.
- Input transfer occurs when in_valid && in_ready. Output pop occurs when out_valid && out_ready.
- FSM states: PAIR_EMPTY, PAIR_HALF.
- PAIR_EMPTY, on accept: hold<=in_act, next state PAIR_HALF. No push.
- PAIR_HALF, on accept: push per-lane unsigned max(hold[lane], in_act[lane]), next state PAIR_EMPTY.
- PAIR_HALF, flush=1 and no accept in that cycle: push hold unchanged (pairing with zero), next state PAIR_EMPTY. This push requires the FIFO not full; otherwise the flush is ignored that cycle and the state stays PAIR_HALF.
- flush together with an accept in PAIR_HALF: the pair completes normally and flush is ignored.
- flush in PAIR_EMPTY: no effect.
- in_ready = !(state==PAIR_HALF && full). in_ready is always 1 in PAIR_EMPTY.
- No push is allowed while full, even if a pop occurs in the same cycle (no bypass).
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. full = (count==DEPTH). out_valid = (count!=0).
- out_data reads the head combinationally from storage. A pushed word appears on out_valid/out_data in the cycle after the push edge (latency 1 from the second accepted vector).
- Lane arithmetic is unsigned 8-bit compare only; no widening or saturation.

Optional Feature:
- Macro: ACT_POOL_MAXPOOL_EN.
- Defined: pairwise max pooling as described above.
- Undefined: FSM and hold register are absent. Every accepted vector is pushed directly, in_ready = !full, and flush is ignored. Output rate equals input rate, with the same 1-cycle latency from accept to out_valid.

Decomposition:
- Package act_pool_pkg: LANES, LANE_W, VEC_W=LANES*LANE_W, pool_state_t enum {PAIR_EMPTY, PAIR_HALF}.
- One sub-module, act_sync_fifo (parameters DEPTH and width; push/pop/full/count), instantiated once.
- The pooling FSM and the lane-max logic stay in the top module.

Test Plan:
- Reset then idle: out_valid=0, fifo_count=0, in_ready=1 for 10 cycles.
- Accept 0x0A140005 then 0x0C0F0020: one push of 0x0C140020; out_valid=1 the next cycle, fifo_count=1.
- Push 16 vectors with out_ready=0 and DEPTH=8: after 8 words in_ready falls to 0 in PAIR_HALF; fifo_count=8; the held vector is not lost. Popping one word lets the pending pair complete.
- Accept one vector 0x000000FF, then flush: pushes 0x000000FF; with the FIFO full the flush is held off until a pop frees space.
- Concurrent push and pop at fifo_count=3: count stays 3; pops return words in FIFO order across the pointer wrap.
- Assert reset while in PAIR_HALF with fifo_count=5: next cycle fifo_count=0, out_valid=0, and the next accepted vector starts a new pair.
